// File: rtl/sram_ctrl_hs.sv
// rtl/sram_ctrl_hs.sv - asynchronous SRAM controller with valid/ready request port, wait states and byte lanes
// Optional feature macro: SRAM_TURNAROUND_EN adds one RD_TURN bus-turnaround cycle after every read.
module sram_ctrl_hs #(
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic            clk_100,
  input  logic            sys_reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic [AW-1:0]   sram_addr,
  inout  wire  [DW-1:0]   sram_data,
  output logic            sram_cs,
  output logic            sram_oe,
  output logic            sram_we,
  output logic [DW/8-1:0] sram_be_n,
  output logic            busy
);

  localparam int         BW     = DW / 8;
  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    RD_TURN,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [3:0]    wait_cnt;
  logic [3:0]    next_cnt;
  logic [DW-1:0] wdata_q;
  logic          data_drv;
  logic          accept;
  logic          rd_done;

  // req_ready is itself registered, so it also masks the first cycle after reset
  assign accept    = (state == IDLE) && req_valid && req_ready;
  assign sram_data = data_drv ? wdata_q : {DW{1'bz}};

  // Next-state and wait-counter reload; the counter reloads on entry to each timed state
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = req_write ? WR_SETUP : RD_STROBE;
          next_cnt   = RD_CNT;
        end
      end
      RD_STROBE: begin
        if (wait_cnt == 4'd0) begin
          rd_done = 1'b1;
`ifdef SRAM_TURNAROUND_EN
          next_state = RD_TURN;
`else
          next_state = IDLE;
`endif
        end else begin
          next_cnt = wait_cnt - 4'd1;
        end
      end
      RD_TURN: next_state = IDLE;
      WR_SETUP: begin
        next_state = WR_PULSE;
        next_cnt   = WR_CNT;
      end
      WR_PULSE: begin
        if (wait_cnt == 4'd0) next_state = WR_HOLD;
        else next_cnt = wait_cnt - 4'd1;
      end
      WR_HOLD: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; every output is registered from the next state so strobes are glitch-free
  // and oe low / bus drive stay mutually exclusive by construction
  always_ff @(posedge clk_100 or posedge sys_reset) begin
    if (sys_reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sram_addr <= '0;
      sram_cs   <= 1'b1;
      sram_oe   <= 1'b1;
      sram_we   <= 1'b1;
      sram_be_n <= {BW{1'b1}};
      data_drv  <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state     <= next_state;
      wait_cnt  <= next_cnt;
      req_ready <= (next_state == IDLE);
      busy      <= (next_state != IDLE);
      rsp_valid <= rd_done;
      sram_cs   <= !(next_state inside {RD_STROBE, WR_SETUP, WR_PULSE, WR_HOLD});
      sram_oe   <= (next_state != RD_STROBE);
      sram_we   <= (next_state != WR_PULSE);
      data_drv  <= (next_state inside {WR_SETUP, WR_PULSE, WR_HOLD});
      if (rd_done) rsp_rdata <= sram_data;
      if (accept) begin
        sram_addr <= req_addr;
        wdata_q   <= req_wdata;
        sram_be_n <= req_write ? ~req_be : {BW{1'b0}};
      end else if (next_state inside {IDLE, RD_TURN}) begin
        sram_be_n <= {BW{1'b1}};
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl_hs.sv
// tb/tb_sram_ctrl_hs.sv - self-checking bench for sram_ctrl_hs (default and swept wait states)
module tb_sram_ctrl_hs;

`ifdef SRAM_TURNAROUND_EN
  localparam int RD_OCC0  = 3;
  localparam int TURN_GAP = 2;
`else
  localparam int RD_OCC0  = 2;
  localparam int TURN_GAP = 1;
`endif

  logic clk_100 = 1'b0;
  logic sys_reset;
  always #5 clk_100 = ~clk_100;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [17:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic [1:0]  req_be    [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic [17:0] sram_addr [2];
  logic        sram_cs   [2];
  logic        sram_oe   [2];
  logic        sram_we   [2];
  logic [1:0]  sram_be_n [2];
  logic        busy      [2];
  wire  [15:0] sram_data0;
  wire  [15:0] sram_data1;

  sram_ctrl_hs #(.AW(18), .DW(16), .RD_WAIT(1), .WR_WAIT(1)) u_dut0 (
    .clk_100(clk_100), .sys_reset(sys_reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .sram_addr(sram_addr[0]), .sram_data(sram_data0), .sram_cs(sram_cs[0]),
    .sram_oe(sram_oe[0]), .sram_we(sram_we[0]), .sram_be_n(sram_be_n[0]), .busy(busy[0])
  );

  sram_ctrl_hs #(.AW(18), .DW(16), .RD_WAIT(0), .WR_WAIT(3)) u_dut1 (
    .clk_100(clk_100), .sys_reset(sys_reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .sram_addr(sram_addr[1]), .sram_data(sram_data1), .sram_cs(sram_cs[1]),
    .sram_oe(sram_oe[1]), .sram_we(sram_we[1]), .sram_be_n(sram_be_n[1]), .busy(busy[1])
  );

  // External SRAM models: read drives while cs/oe low, write stores lanes while cs/we low
  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];
  assign sram_data0 = (!sram_cs[0] && !sram_oe[0]) ? mem0[sram_addr[0]] : 16'hzzzz;
  assign sram_data1 = (!sram_cs[1] && !sram_oe[1]) ? mem1[sram_addr[1]] : 16'hzzzz;

  always @(negedge clk_100) begin
    if (!sram_cs[0] && !sram_we[0]) begin
      if (!sram_be_n[0][0]) mem0[sram_addr[0]][7:0]  = sram_data0[7:0];
      if (!sram_be_n[0][1]) mem0[sram_addr[0]][15:8] = sram_data0[15:8];
    end
    if (!sram_cs[1] && !sram_we[1]) begin
      if (!sram_be_n[1][0]) mem1[sram_addr[1]][7:0]  = sram_data1[7:0];
      if (!sram_be_n[1][1]) mem1[sram_addr[1]][15:8] = sram_data1[15:8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  int n_rd  [2] = '{0, 0};
  int n_rsp [2] = '{0, 0};
  int lat_exp [2] = '{3, 2};

  int cyc = 0;
  int acc_cyc [2] = '{0, 0};
  int rd_acc  [2] = '{0, 0};
  int we_run  [2] = '{0, 0};
  int we_len  [2] = '{0, 0};
  int rdy_run [2] = '{0, 0};
  int rdy_len [2] = '{0, 0};
  bit prev_rsp [2] = '{1'b0, 1'b0};
  int viol = 0;
  bit turn_on = 1'b0;
  int turn_cnt = 0;
  int turn_gap = -1;

  // Handshake and cycle bookkeeping on the active edge (pre-edge values are sampled here)
  always @(posedge clk_100) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc_cyc[i] = cyc;
        if (!req_write[i]) rd_acc[i] = cyc;
      end
    end
  end

  // Scoreboard, pulse-shape and contention monitors on the opposite edge
  always @(negedge clk_100) begin
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i]) begin
        logic [15:0] e;
        int qs;
        n_rsp[i]++;
        check("rsp_latency", cyc + 1 - rd_acc[i], lat_exp[i]);
        qs = (i == 0) ? exp_q0.size() : exp_q1.size();
        check("rsp_expected", (qs != 0), 1);
        if (qs != 0) begin
          e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check("rsp_rdata", rsp_rdata[i], e);
        end
      end
      if (prev_rsp[i]) check("rsp_pulse_width", rsp_valid[i], 0);
      prev_rsp[i] = rsp_valid[i];
      if (!sram_we[i]) we_run[i]++;
      else if (we_run[i] != 0) begin we_len[i] = we_run[i]; we_run[i] = 0; end
      if (!req_ready[i]) rdy_run[i]++;
      else if (rdy_run[i] != 0) begin rdy_len[i] = rdy_run[i]; rdy_run[i] = 0; end
    end
    if (!sram_oe[0] && u_dut0.data_drv) viol++;
    if (!sram_oe[1] && u_dut1.data_drv) viol++;
    if (!sram_oe[0]) begin
      turn_on = 1'b1; turn_cnt = 0;
    end else if (turn_on && u_dut0.data_drv) begin
      turn_gap = turn_cnt; turn_on = 1'b0;
    end else if (turn_on && sram_cs[0]) begin
      turn_cnt++;
    end
  end

  task automatic do_req(input int i, input bit wr, input logic [17:0] a, input logic [15:0] d,
                        input logic [1:0] be, input logic [15:0] exp_rd);
    int k = 0;
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d; req_be[i] = be;
    while (!req_ready[i] && k < 100) begin @(posedge clk_100); #1; k++; end
    check("accept_timeout", (k < 100), 1);
    if (!wr) begin
      n_rd[i]++;
      if (i == 0) exp_q0.push_back(exp_rd); else exp_q1.push_back(exp_rd);
    end
    @(posedge clk_100); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int k = 0;
    while ((busy[i] || !req_ready[i]) && k < 100) begin @(posedge clk_100); #1; k++; end
    check("idle_timeout", (k < 100), 1);
    @(posedge clk_100); #1;
  endtask

  typedef struct {
    bit          wr;
    logic [17:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [13];

  initial begin : main
    int k;
    int first_acc;
    int rsp_before;
    vecs[0]  = '{1'b1, 18'h3FFFF, 16'hA55A, 2'b11, 16'h0000};
    vecs[1]  = '{1'b0, 18'h3FFFF, 16'h0000, 2'b00, 16'hA55A};
    vecs[2]  = '{1'b1, 18'h00010, 16'hA55A, 2'b11, 16'h0000};
    vecs[3]  = '{1'b1, 18'h00010, 16'h1234, 2'b01, 16'h0000};
    vecs[4]  = '{1'b0, 18'h00010, 16'h0000, 2'b00, 16'hA534};
    vecs[5]  = '{1'b1, 18'h00010, 16'hFFFF, 2'b00, 16'h0000};
    vecs[6]  = '{1'b0, 18'h00010, 16'h0000, 2'b00, 16'hA534};
    vecs[7]  = '{1'b1, 18'h00001, 16'h0000, 2'b11, 16'h0000};
    vecs[8]  = '{1'b1, 18'h00001, 16'hBEEF, 2'b10, 16'h0000};
    vecs[9]  = '{1'b0, 18'h00001, 16'h0000, 2'b00, 16'hBE00};
    vecs[10] = '{1'b1, 18'h20000, 16'hC3C3, 2'b11, 16'h0000};
    vecs[11] = '{1'b0, 18'h20000, 16'h0000, 2'b00, 16'hC3C3};
    vecs[12] = '{1'b0, 18'h3FFFF, 16'h0000, 2'b00, 16'hA55A};

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0;
    end
    sys_reset = 1'b1;
    repeat (3) @(posedge clk_100);
    #1;
    check("reset_req_ready", req_ready[0], 0);
    check("reset_rsp_valid", rsp_valid[0], 0);
    check("reset_rsp_rdata", rsp_rdata[0], 0);
    check("reset_busy", busy[0], 0);
    check("reset_cs_oe_we", {sram_cs[0], sram_oe[0], sram_we[0]}, 3'b111);
    check("reset_be_n", sram_be_n[0], 2'b11);
    check("reset_addr", sram_addr[0], 0);
    check("reset_bus_drive", u_dut0.data_drv, 0);
    @(negedge clk_100);
    sys_reset = 1'b0;
    #1;
    check("release_ready_low", req_ready[0], 0);
    @(posedge clk_100); #1;
    check("release_ready_high", req_ready[0], 1);

    for (int v = 0; v < 13; v++) begin
      do_req(0, vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].be, vecs[v].exp);
      wait_idle(0);
      if (vecs[v].wr) begin
        check("wr_we_low_cycles", we_len[0], 2);
        check("wr_ready_low_cycles", rdy_len[0], 4);
      end else begin
        check("rd_ready_low_cycles", rdy_len[0], RD_OCC0);
      end
    end

    do_req(0, 1'b1, 18'h00002, 16'h4444, 2'b11, 16'h0);
    wait_idle(0);
    check("rdata_hold_after_write", rsp_rdata[0], 16'hA55A);

    // Back-to-back write then read with req_valid held and fields changed while busy
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 18'h3FFFF;
    req_wdata[0] = 16'h5AA5; req_be[0] = 2'b11;
    @(posedge clk_100); #1;
    first_acc = acc_cyc[0];
    req_write[0] = 1'b0; req_wdata[0] = 16'hDEAD; req_be[0] = 2'b00;
    n_rd[0]++;
    exp_q0.push_back(16'h5AA5);
    k = 0;
    while (!req_ready[0] && k < 100) begin @(posedge clk_100); #1; k++; end
    check("b2b_timeout", (k < 100), 1);
    @(posedge clk_100); #1;
    req_valid[0] = 1'b0;
    check("b2b_ready_low_cycles", rdy_len[0], 4);
    check("b2b_accept_gap", acc_cyc[0] - first_acc, 5);
    wait_idle(0);

    // Read immediately followed by a write: idle cs cycles between oe release and bus drive
    do_req(0, 1'b0, 18'h00010, 16'h0, 2'b00, 16'hA534);
    do_req(0, 1'b1, 18'h00020, 16'h1111, 2'b11, 16'h0);
    wait_idle(0);
    check("turnaround_cs_gap", turn_gap, TURN_GAP);

    // Swept instance: RD_WAIT=0, WR_WAIT=3
    do_req(1, 1'b1, 18'h00005, 16'h1357, 2'b11, 16'h0);
    wait_idle(1);
    check("sweep_we_low_cycles", we_len[1], 4);
    check("sweep_wr_occupancy", rdy_len[1], 6);
    do_req(1, 1'b0, 18'h00005, 16'h0, 2'b00, 16'h1357);
    wait_idle(1);
    check("sweep_rd_ready_low", rdy_len[1], 1);

    // Reset in the middle of a write pulse
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 18'h00100;
    req_wdata[0] = 16'h7777; req_be[0] = 2'b11;
    k = 0;
    while (sram_we[0] && k < 50) begin
      @(posedge clk_100); #1; k++;
      if (!req_ready[0]) req_valid[0] = 1'b0;
    end
    check("rst_we_pulse_seen", (k < 50), 1);
    rsp_before = n_rsp[0];
    #2;
    sys_reset = 1'b1;
    #1;
    check("rst_mid_cs_oe_we", {sram_cs[0], sram_oe[0], sram_we[0]}, 3'b111);
    check("rst_mid_bus_drive", u_dut0.data_drv, 0);
    check("rst_mid_busy", busy[0], 0);
    @(negedge clk_100);
    sys_reset = 1'b0;
    @(posedge clk_100); #1;
    check("rst_mid_ready_after", req_ready[0], 1);
    repeat (3) @(posedge clk_100);
    #1;
    check("rst_mid_no_rsp", n_rsp[0], rsp_before);

    check("rsp_count0", n_rsp[0], n_rd[0]);
    check("rsp_count1", n_rsp[1], n_rd[1]);
    check("queue0_empty", exp_q0.size(), 0);
    check("queue1_empty", exp_q1.size(), 0);
    check("oe_bus_contention", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
